// File: rtl/store_demux_pkg.sv
// Shared types and constants for the data-side store/load router.
package store_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic SLV_RAM = 1'b0;
  localparam logic SLV_IO  = 1'b1;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/store_demux_rdata_sel.sv
// Response data register: picks slave read data by destination,
// or an override value for stores and timeouts.
module rdata_sel
  import store_demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ovr,
  input  logic [DATA_W-1:0] ovr_data,
  input  logic              dest,
  input  logic [DATA_W-1:0] s0_rdata,
  input  logic [DATA_W-1:0] s1_rdata,
  output logic [DATA_W-1:0] rdata_q
);

  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (load) begin
      if (ovr)
        rdata_d = ovr_data;
      else if (dest == SLV_IO)
        rdata_d = s1_rdata;
      else
        rdata_d = s0_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

endmodule

// File: rtl/store_demux.sv
// Routes one core load/store port to data RAM or MMIO by one address
// bit, holds the request until accepted and guards it with a watchdog.
module store_demux
  import store_demux_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 31,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              s0_valid,
  input  logic              s0_ready,
  output logic              s0_we,
  output logic [ADDR_W-1:0] s0_addr,
  output logic [DATA_W-1:0] s0_wdata,
  input  logic              s0_rvalid,
  input  logic [DATA_W-1:0] s0_rdata,
  output logic              s1_valid,
  input  logic              s1_ready,
  output logic              s1_we,
  output logic [ADDR_W-1:0] s1_addr,
  output logic [DATA_W-1:0] s1_wdata,
  input  logic              s1_rvalid,
  input  logic [DATA_W-1:0] s1_rdata
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dest_q, dest_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;

  logic              sel_ready;
  logic              sel_rvalid;
  logic              wd_hit;
  logic [WD_W-1:0]   wd_inc;
  logic              rd_load;
  logic              rd_ovr;
  logic [DATA_W-1:0] rd_ovr_data;

  assign sel_ready  = (dest_q == SLV_IO) ? s1_ready  : s0_ready;
  assign sel_rvalid = (dest_q == SLV_IO) ? s1_rvalid : s0_rvalid;
  assign wd_hit     = (wdog_q == WD_MAX);
  // Saturate so a stuck slave can never wrap the watchdog.
  assign wd_inc     = wd_hit ? wdog_q : wdog_q + WD_W'(1);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dest_d      = dest_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    rd_load     = 1'b0;
    rd_ovr      = 1'b0;
    rd_ovr_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          dest_d  = req_addr[SEL_BIT];
          wdog_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d = wd_inc;
        if (sel_ready) begin
          if (we_q) begin
            rd_load = 1'b1;
            rd_ovr  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end else if (wd_hit) begin
          rd_load     = 1'b1;
          rd_ovr      = 1'b1;
          rd_ovr_data = DATA_W'(DEAD_BEEF);
          err_d       = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_WAIT_RD: begin
        wdog_d = wd_inc;
        if (sel_rvalid) begin
          rd_load = 1'b1;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (wd_hit) begin
          rd_load     = 1'b1;
          rd_ovr      = 1'b1;
          rd_ovr_data = DATA_W'(DEAD_BEEF);
          err_d       = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dest_q  <= dest_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  rdata_sel #(
    .DATA_W(DATA_W)
  ) u_rdata_sel (
    .clk     (clk),
    .rst     (rst),
    .load    (rd_load),
    .ovr     (rd_ovr),
    .ovr_data(rd_ovr_data),
    .dest    (dest_q),
    .s0_rdata(s0_rdata),
    .s1_rdata(s1_rdata),
    .rdata_q (rsp_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = err_q;

  assign s0_valid = (state_q == ST_ISSUE) && (dest_q == SLV_RAM);
  assign s1_valid = (state_q == ST_ISSUE) && (dest_q == SLV_IO);
  assign s0_we    = we_q;
  assign s1_we    = we_q;
  assign s0_addr  = addr_q;
  assign s1_addr  = addr_q;
  assign s0_wdata = wdata_q;
  assign s1_wdata = wdata_q;

endmodule

// File: tb/tb_store_demux.sv
// Directed bench for store_demux with TIMEOUT=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_store_demux;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        s0_valid, s0_ready, s0_we, s0_rvalid;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic        s1_valid, s1_ready, s1_we, s1_rvalid;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;

  int errors = 0;
  int checks = 0;

  store_demux #(
    .ADDR_W (32),
    .DATA_W (32),
    .SEL_BIT(31),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_we    (s0_we),
    .s0_addr  (s0_addr),
    .s0_wdata (s0_wdata),
    .s0_rvalid(s0_rvalid),
    .s0_rdata (s0_rdata),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_we    (s1_we),
    .s1_addr  (s1_addr),
    .s1_wdata (s1_wdata),
    .s1_rvalid(s1_rvalid),
    .s1_rdata (s1_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    s0_ready  = 1'b0;
    s0_rvalid = 1'b0;
    s0_rdata  = '0;
    s1_ready  = 1'b0;
    s1_rvalid = 1'b0;
    s1_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    tick();
    tick();
    checks++;
    if ({req_ready, s0_valid, s1_valid, rsp_valid, rsp_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {req_ready, s0_valid, s1_valid, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h want=0", rsp_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0010;
    req_wdata = 32'hCAFE_F00D;
    s0_ready  = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_req_ready got=%b want=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    checks++;
    if ({s0_valid, s1_valid, s0_we} !== 3'b101) begin
      errors++;
      $display("FAIL store_c1_valid got=%b want=101",
               {s0_valid, s1_valid, s0_we});
    end
    checks++;
    if (s0_addr !== 32'h10 || s0_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL store_c1_bus got=%h/%h want=00000010/cafef00d",
               s0_addr, s0_wdata);
    end
    tick();
    s0_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, s0_valid, s1_valid, req_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL store_c2_rsp got=%b want=10000",
               {rsp_valid, rsp_err, s0_valid, s1_valid, req_ready});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_c2_rdata got=%h want=0", rsp_rdata);
    end
    tick();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL store_c3_idle got=%b want=10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_load_io();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({s1_valid, s0_valid, s1_we} !== 3'b100 || s1_addr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL load_io_c1 got=%b/%h want=100/80000004",
               {s1_valid, s0_valid, s1_we}, s1_addr);
    end
    tick();
    tick();
    s1_ready = 1'b1;
    checks++;
    if (s1_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_io_c3_hold got=%b want=1", s1_valid);
    end
    tick();
    s1_ready  = 1'b0;
    s1_rvalid = 1'b1;
    s1_rdata  = 32'h1234_5678;
    checks++;
    if ({s1_valid, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL load_io_c4 got=%b want=00", {s1_valid, rsp_valid});
    end
    tick();
    s1_rvalid = 1'b0;
    s1_rdata  = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_io_c5 got=%b%b/%h want=10/12345678",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_io_hold got=%b/%h want=0/12345678",
               rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_stray_rvalid();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0020;
    tick();
    req_valid = 1'b0;
    s0_ready  = 1'b1;
    s0_rvalid = 1'b1;
    s0_rdata  = 32'h1111_1111;
    s1_ready  = 1'b1;
    s1_rvalid = 1'b1;
    s1_rdata  = 32'hFFFF_FFFF;
    tick();
    s0_ready  = 1'b0;
    s0_rvalid = 1'b0;
    s1_ready  = 1'b0;
    tick();
    s1_rvalid = 1'b0;
    s0_rvalid = 1'b1;
    s0_rdata  = 32'hA5A5_0001;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ignored got=%b want=0", rsp_valid);
    end
    tick();
    s0_rvalid = 1'b0;
    s0_rdata  = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_rsp got=%b%b/%h want=10/a5a50001",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0040;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || s0_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_c5 got=%b%b want=01", rsp_valid, s0_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL timeout_c6 got=%b%b/%h want=11/deadbeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_c7 got=%b%b%b want=101",
               req_ready, rsp_valid, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0008;
    tick();
    req_valid = 1'b0;
    s0_ready  = 1'b1;
    tick();
    s0_ready = 1'b0;
    checks++;
    if ({req_ready, s0_valid, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_wait got=%b want=000",
               {req_ready, s0_valid, rsp_valid});
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, s0_valid, s1_valid, rsp_valid, rsp_err} !== 5'b10000 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async got=%b/%h want=10000/0",
               {req_ready, s0_valid, s1_valid, rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    rst       = 1'b0;
    s0_rvalid = 1'b1;
    s0_rdata  = 32'h7777_7777;
    pulses    = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      s0_rvalid = 1'b0;
      if (rsp_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_no_rsp got=%0d/%b want=0/1", pulses, req_ready);
    end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h0BAD_CAFE;
    s1_ready  = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (s1_valid !== 1'b1 || s1_wdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL rstmid_next_issue got=%b/%h want=1/0badcafe",
               s1_valid, s1_wdata);
    end
    tick();
    s1_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_next_rsp got=%b%b/%h want=10/0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout_tie();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8000_0100;
    tick();
    req_valid = 1'b0;
    s1_ready  = 1'b1;
    tick();
    s1_ready = 1'b0;
    tick();
    tick();
    tick();
    s1_rvalid = 1'b1;
    s1_rdata  = 32'h55AA_55AA;
    tick();
    s1_rvalid = 1'b0;
    s1_rdata  = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL tie_rsp got=%b%b/%h want=10/55aa55aa",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    s0_ready  = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h1;
    tick();
    req_addr  = 32'h0000_0200;
    req_wdata = 32'h2;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got=%b%b want=10", rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got=%b want=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (s0_valid !== 1'b1 || s0_addr !== 32'h200 || s0_wdata !== 32'h2) begin
      errors++;
      $display("FAIL b2b_second got=%b/%h/%h want=1/00000200/00000002",
               s0_valid, s0_addr, s0_wdata);
    end
    tick();
    s0_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rsp got=%b%b want=10", rsp_valid, rsp_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_io();
    test_stray_rvalid();
    test_timeout();
    test_reset_mid();
    test_timeout_tie();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_demux.md
# store_demux

Data-side request router for the single-cycle RISC-V core: one CPU load/store port in, two slave ports out (slave 0 = data RAM, slave 1 = memory-mapped IO). Each request is registered, steered to one slave by one address bit, and held until accepted. For loads, the block waits for the read data and returns it to the core. The core stalls on `req_ready`/`rsp_valid`. A watchdog terminates hung transactions with an error.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `SEL_BIT`, default 31: address bit selecting the slave (0 → slave 0, 1 → slave 1).
- `TIMEOUT`, default 255: maximum cycles spent waiting on a slave (≥ 1).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the core presents a request.
- `req_ready` out 1: the block accepts a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: load data (0 for stores).
- `rsp_err` out 1: the transaction timed out.
- `s0_valid`, `s1_valid` out 1: request valid toward slave N.
- `s0_ready`, `s1_ready` in 1: slave N accepts the request.
- `s0_we`, `s1_we` out 1: registered copy of `req_we`.
- `s0_addr`, `s1_addr` out ADDR_W: registered address.
- `s0_wdata`, `s1_wdata` out DATA_W: registered store data.
- `s0_rvalid`, `s1_rvalid` in 1: slave N read data valid.
- `s0_rdata`, `s1_rdata` in DATA_W: slave N read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: capture we/addr/wdata and dest=`req_addr[SEL_BIT]`, clear the watchdog, then go to ISSUE.
- **ISSUE**
  - Assert `s<dest>_valid` only. All `sN_we/addr/wdata` outputs are driven from the capture registers on both ports, stable until accept.
  - On `s<dest>_ready`:
    - store: go to DONE with rdata=0.
    - load: go to WAIT_RD.
- **WAIT_RD**
  - On `s<dest>_rvalid`: capture `s<dest>_rdata` and go to DONE.
- **DONE**
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - `rsp_rdata`/`rsp_err` come from registers and hold their value until the next DONE.
- **Watchdog**
  - Increments every cycle in ISSUE or WAIT_RD.
  - When it reaches TIMEOUT and the awaited event is absent, go to DONE with `rsp_err`=1 and `rsp_rdata`=32'hDEAD_BEEF (truncated/zero-extended to DATA_W).
  - Counter width is $clog2(TIMEOUT+1); it never wraps.
- Ignored inputs:
  - `rvalid`/`ready` from the non-selected slave.
  - `rvalid` seen in ISSUE.
  - `req_valid` outside IDLE.
- A slave event that arrives on the same cycle as the timeout wins: normal completion, `rsp_err`=0.
- Only one outstanding transaction at a time; responses are returned in order by construction.

## Timing
- Reset (asynchronous, mid-transaction included): state=IDLE, `req_ready`=1, `s0_valid`=`s1_valid`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, capture registers=0, watchdog=0.
- Any in-flight transaction is abandoned on reset; no response is issued for it.
- Store, slave always ready:
  - accept at cycle 0
  - `sN_valid` at cycle 1
  - `rsp_valid` at cycle 2 (latency 2).
- Load, slave ready at cycle 1 and `rvalid` at cycle 2: `rsp_valid` at cycle 3 (latency 3).
- Each extra wait cycle on `ready` or `rvalid` adds exactly one cycle of latency.
- Timeout response appears TIMEOUT+1 cycles after entering ISSUE, worst case.
- Back-to-back: `req_ready` returns 1 the cycle after DONE, so the minimum request spacing is 3 cycles for stores.
- `sN_valid` is registered, never combinational from `req_valid`, and deasserts in the cycle after the handshake.

## Structure
- Shared package holds:
  - the state enum (IDLE/ISSUE/WAIT_RD/DONE)
  - slave index constants SLV_RAM=0 and SLV_IO=1
  - the DEAD_BEEF error constant.
- One sub-module, `rdata_sel`: a registered 2:1 DATA_W selector that picks `s0_rdata`/`s1_rdata` by dest on `rvalid`, feeding the capture register.
- Everything else stays in one file.

## Test plan
- Store 0x0000_0010 ← 0xCAFE_F00D, `s0_ready`=1:
  - `s0_valid` at cycle 1 with addr 0x10 and wdata 0xCAFEF00D; `s1_valid`=0 throughout.
  - `rsp_valid` at cycle 2 with `rsp_rdata`=0 and `rsp_err`=0.
- Load 0x8000_0004, `s1_ready` delayed 2 cycles, `s1_rvalid` with 0x1234_5678 one cycle after accept:
  - `rsp_rdata`=0x12345678 and `rsp_valid` at cycle 5.
- Load to slave 0 while `s1_rvalid` pulses with 0xFFFF_FFFF:
  - the stray pulse is ignored.
  - Response carries slave 0 data only.
- Slave 0 never ready, TIMEOUT=4:
  - `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0xDEADBEEF at cycle 6.
  - `req_ready`=1 at cycle 7.
- `rst` asserted during WAIT_RD:
  - all outputs at reset values immediately (asynchronously).
  - No `rsp_valid` pulse.
  - Next request completes normally.
- `s1_rvalid` on the same cycle the watchdog hits TIMEOUT:
  - normal completion with `rsp_err`=0.
